// File: rtl/led_pkg.sv
// Shared definitions for the scrolling 7-segment display driver:
// character code width, special character codes and segment patterns.
package led_pkg;

   localparam int CHAR_W = 6;

   typedef logic [CHAR_W-1:0] char_t;
   typedef logic [6:0]        seg_t;

   // Special character codes; everything from CHAR_BLANK upward is blank.
   localparam char_t CHAR_DASH  = 6'd36;
   localparam char_t CHAR_BLANK = 6'd37;

   // Active-low segment patterns, bit 6 = segment a, bit 0 = segment g.
   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_DASH  = 7'b1111110;

endpackage

// File: rtl/led_char_decoder.sv
// Combinational character-code to active-low segment decoder.
// Codes 0-9 are digits, 10-35 letters A-Z, 36 a dash, 37-63 blank.
module led_char_decoder
   import led_pkg::*;
(
   input  logic [CHAR_W-1:0] i_code,
   output logic [6:0]        o_seg
);

   // Segment lookup; unlisted codes fall through to blank.
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_code)
         6'd0:  o_seg = 7'b0000001;
         6'd1:  o_seg = 7'b1001111;
         6'd2:  o_seg = 7'b0010010;
         6'd3:  o_seg = 7'b0000110;
         6'd4:  o_seg = 7'b1001100;
         6'd5:  o_seg = 7'b0100100;
         6'd6:  o_seg = 7'b0100000;
         6'd7:  o_seg = 7'b0001111;
         6'd8:  o_seg = 7'b0000000;
         6'd9:  o_seg = 7'b0000100;
         6'd10: o_seg = 7'b0001000; // A
         6'd11: o_seg = 7'b1100000; // b
         6'd12: o_seg = 7'b0110001; // C
         6'd13: o_seg = 7'b1000010; // d
         6'd14: o_seg = 7'b0110000; // E
         6'd15: o_seg = 7'b0111000; // F
         6'd16: o_seg = 7'b0100001; // G
         6'd17: o_seg = 7'b1001000; // H
         6'd18: o_seg = 7'b1111001; // I
         6'd19: o_seg = 7'b1000011; // J
         6'd20: o_seg = 7'b0101000; // K (approximation)
         6'd21: o_seg = 7'b1110001; // L
         6'd22: o_seg = 7'b0101011; // M (approximation)
         6'd23: o_seg = 7'b1101010; // n
         6'd24: o_seg = 7'b1100010; // o
         6'd25: o_seg = 7'b0011000; // P
         6'd26: o_seg = 7'b0001100; // q
         6'd27: o_seg = 7'b1111010; // r
         6'd28: o_seg = 7'b0100100; // S
         6'd29: o_seg = 7'b1110000; // t
         6'd30: o_seg = 7'b1000001; // U
         6'd31: o_seg = 7'b1100011; // v
         6'd32: o_seg = 7'b1010101; // W (approximation)
         6'd33: o_seg = 7'b1001000; // X (same as H)
         6'd34: o_seg = 7'b1000100; // y
         6'd35: o_seg = 7'b0010010; // Z
         CHAR_DASH: o_seg = SEG_DASH;
         default:   o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/led_scroll_driver.sv
// Multiplexed common-anode 7-segment driver with a scrolling message
// buffer. One digit is lit per refresh slot; the first cycle of every
// slot is blanked to avoid ghosting. The window into the message moves
// one character every SCROLL_DIV enabled cycles.
module led_scroll_driver
   import led_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int MSG_LEN     = 16,
   parameter int REFRESH_DIV = 16,
   parameter int SCROLL_DIV  = 1 << 20,
   parameter int ADDR_W      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  msg_we,
   input  logic [ADDR_W-1:0]     msg_addr,
   input  logic [CHAR_W-1:0]     msg_char,
   input  logic                  scroll_en,
   input  logic                  scroll_clr,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            LED
);

   localparam int RF_W = $clog2(REFRESH_DIV);
   localparam int DG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   localparam logic [RF_W-1:0]   RF_LAST  = RF_W'(REFRESH_DIV - 1);
   localparam logic [DG_W-1:0]   DG_LAST  = DG_W'(NUM_DIGITS - 1);
   localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(SCROLL_DIV - 1);
   localparam logic [ADDR_W-1:0] OFF_LAST = ADDR_W'(MSG_LEN - 1);
   // One extra bit so MSG_LEN itself is representable for range checks.
   localparam logic [ADDR_W:0]   LEN_X    = (ADDR_W + 1)'(MSG_LEN);

   logic [RF_W-1:0]       r_refresh_cnt;
   logic [DG_W-1:0]       r_digit_idx;
   logic [SC_W-1:0]       r_scroll_cnt;
   logic [ADDR_W-1:0]     r_offset;
   logic [CHAR_W-1:0]     r_buf [MSG_LEN];
   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_led;

   logic                  w_addr_ok;
   logic                  w_slot_live;
   logic [ADDR_W:0]       w_sum;
   logic [ADDR_W-1:0]     w_rd_idx;
   logic [CHAR_W-1:0]     w_char;
   logic [6:0]            w_seg;
   logic [NUM_DIGITS-1:0] w_an_next;

   assign w_addr_ok   = ({1'b0, msg_addr} < LEN_X);
   assign w_slot_live = (r_refresh_cnt != '0);

   // offset and digit_idx are both below MSG_LEN, so one conditional
   // subtraction is enough to wrap the sum.
   assign w_sum    = {1'b0, r_offset} + (ADDR_W + 1)'(r_digit_idx);
   assign w_rd_idx = (w_sum >= LEN_X) ? ADDR_W'(w_sum - LEN_X) : ADDR_W'(w_sum);
   assign w_char   = r_buf[w_rd_idx];

   led_char_decoder u_dec (
      .i_code (w_char),
      .o_seg  (w_seg)
   );

   // One-hot-low anode pattern, all off during the blanking cycle.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign w_an_next[gi] = !(w_slot_live && (r_digit_idx == DG_W'(gi)));
   end

   // Message buffer: blanked on reset, out-of-range writes dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MSG_LEN; i++) r_buf[i] <= CHAR_BLANK;
      end else if (msg_we && w_addr_ok) begin
         r_buf[msg_addr] <= msg_char;
      end
   end

   // Refresh slot counter and the digit it selects.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_refresh_cnt <= '0;
         r_digit_idx   <= '0;
      end else if (r_refresh_cnt == RF_LAST) begin
         r_refresh_cnt <= '0;
         r_digit_idx   <= (r_digit_idx == DG_LAST) ? '0 : r_digit_idx + 1'b1;
      end else begin
         r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
   end

   // Scroll prescaler and message offset; clear wins over enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_scroll_cnt <= '0;
         r_offset     <= '0;
      end else if (scroll_clr) begin
         r_scroll_cnt <= '0;
         r_offset     <= '0;
      end else if (scroll_en) begin
         if (r_scroll_cnt == SC_LAST) begin
            r_scroll_cnt <= '0;
            r_offset     <= (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;
         end else begin
            r_scroll_cnt <= r_scroll_cnt + 1'b1;
         end
      end
   end

   // Registered pin drivers; segments are also dark in the blank cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_an  <= '1;
         r_led <= SEG_BLANK;
      end else begin
         r_an  <= w_an_next;
         r_led <= w_slot_live ? w_seg : SEG_BLANK;
      end
   end

   assign an  = r_an;
   assign LED = r_led;

endmodule

// File: tb/tb_led_scroll_driver.sv
// Randomized self-checking bench for led_scroll_driver. The reference model
// describes the display from elapsed-cycle arithmetic: slot position is
// derived from cycles since reset, offset from enabled cycles since the last
// clear, and segment patterns from lists of lit segment letters.
module tb_led_scroll_driver;

   localparam int ND = 4;
   localparam int ML = 8;
   localparam int RD = 4;
   localparam int SD = 32;

   logic       clk        = 1'b0;
   logic       reset      = 1'b0;
   logic       msg_we     = 1'b0;
   logic [2:0] msg_addr   = '0;
   logic [5:0] msg_char   = '0;
   logic       scroll_en  = 1'b0;
   logic       scroll_clr = 1'b0;
   logic [3:0] an;
   logic [6:0] LED;

   led_scroll_driver #(
      .NUM_DIGITS  (ND),
      .MSG_LEN     (ML),
      .REFRESH_DIV (RD),
      .SCROLL_DIV  (SD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .msg_we     (msg_we),
      .msg_addr   (msg_addr),
      .msg_char   (msg_char),
      .scroll_en  (scroll_en),
      .scroll_clr (scroll_clr),
      .an         (an),
      .LED        (LED)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Lit segments per character code, as letters a..g.
   string seg_lit [64];

   function automatic logic [6:0] seg_of(input int code);
      logic [6:0] r;
      string s;
      int idx;
      r = 7'h7F;
      s = seg_lit[code];
      for (int i = 0; i < s.len(); i++) begin
         idx = int'(s[i]) - 97;
         r[6 - idx] = 1'b0;
      end
      return r;
   endfunction

   // Reference model state.
   int         m_n;        // cycles since reset release
   int         m_en;       // enabled cycles since last clear
   logic [5:0] m_mem [ML];
   // What the outputs should currently show (set by step).
   int         e_digit;
   int         e_off;
   bit         e_active;

   task automatic model_reset();
      m_n  = 0;
      m_en = 0;
      for (int i = 0; i < ML; i++) m_mem[i] = 6'd37;
   endtask

   // One clock: predict, clock, compare, then fold this cycle's inputs in.
   task automatic step(input string tag);
      logic [3:0] ean;
      logic [6:0] eled;
      e_digit  = (m_n / RD) % ND;
      e_active = (m_n % RD) != 0;
      e_off    = (m_en / SD) % ML;
      ean      = e_active ? ~(4'b0001 << e_digit) : 4'hF;
      eled     = seg_of(int'(m_mem[(e_off + e_digit) % ML]));
      @(posedge clk);
      #1;
      chk({tag, "_an"}, an, ean);
      if (e_active) chk({tag, "_led"}, LED, eled);
      if (msg_we) m_mem[msg_addr] = msg_char;
      if (scroll_clr) m_en = 0;
      else if (scroll_en) m_en++;
      m_n++;
      @(negedge clk);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic write(input int addr, input int ch, input string tag);
      msg_we   = 1'b1;
      msg_addr = 3'(addr);
      msg_char = 6'(ch);
      $display("write %s: addr=%0d char=%0d", tag, addr, ch);
      step(tag);
      msg_we = 1'b0;
   endtask

   // Asynchronous reset between clock edges, released at a falling edge.
   task automatic do_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      chk({tag, "_an_async"}, an, 4'hF);
      chk({tag, "_led_async"}, LED, 7'h7F);
      @(posedge clk);
      #1;
      chk({tag, "_an_hold"}, an, 4'hF);
      chk({tag, "_led_hold"}, LED, 7'h7F);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      $display("reset %s released", tag);
   endtask

   initial begin
      int cnt_blank;
      int cnt_dig [ND];
      bit seen;
      int off_before;
      int cur_off;

      seg_lit[0]  = "abcdef";  seg_lit[1]  = "bc";     seg_lit[2]  = "abdeg";
      seg_lit[3]  = "abcdg";   seg_lit[4]  = "bcfg";   seg_lit[5]  = "acdfg";
      seg_lit[6]  = "acdefg";  seg_lit[7]  = "abc";    seg_lit[8]  = "abcdefg";
      seg_lit[9]  = "abcdfg";  seg_lit[10] = "abcefg"; seg_lit[11] = "cdefg";
      seg_lit[12] = "adef";    seg_lit[13] = "bcdeg";  seg_lit[14] = "adefg";
      seg_lit[15] = "aefg";    seg_lit[16] = "acdef";  seg_lit[17] = "bcefg";
      seg_lit[18] = "ef";      seg_lit[19] = "bcde";   seg_lit[20] = "acefg";
      seg_lit[21] = "def";     seg_lit[22] = "ace";    seg_lit[23] = "ceg";
      seg_lit[24] = "cdeg";    seg_lit[25] = "abefg";  seg_lit[26] = "abcfg";
      seg_lit[27] = "eg";      seg_lit[28] = "acdfg";  seg_lit[29] = "defg";
      seg_lit[30] = "bcdef";   seg_lit[31] = "cde";    seg_lit[32] = "bdf";
      seg_lit[33] = "bcefg";   seg_lit[34] = "bcdfg";  seg_lit[35] = "abdeg";
      seg_lit[36] = "g";
      for (int i = 37; i < 64; i++) seg_lit[i] = "";

      // Power-on reset.
      repeat (2) @(posedge clk);
      #1;
      chk("por_an", an, 4'hF);
      chk("por_led", LED, 7'h7F);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      run(16, "blank_frame");

      // Reset in the middle of a frame.
      run(6, "pre_rst");
      do_reset("mid");
      run(16, "post_rst");

      // Static display of 1,2,3,4.
      for (int i = 0; i < 4; i++) write(i, i + 1, "static");
      run(3, "static_settle");
      cnt_blank = 0;
      for (int d = 0; d < ND; d++) cnt_dig[d] = 0;
      for (int i = 0; i < 16; i++) begin
         step("static");
         if (an == 4'hF) cnt_blank++;
         for (int d = 0; d < ND; d++)
            if (an == ~(4'b0001 << d)) cnt_dig[d]++;
         if (e_active && e_digit == 0) chk("static_dig0_one", LED, 7'b1001111);
      end
      chk("static_blank_cycles", cnt_blank, 4);
      for (int d = 0; d < ND; d++) chk("static_active_cycles", cnt_dig[d], 3);

      // Decoder sweep through address 0 with the window at offset 0.
      scroll_clr = 1'b1;
      step("sweep_clr");
      scroll_clr = 1'b0;
      for (int c = 0; c < 64; c++) begin
         write(0, c, "sweep");
         seen = 1'b0;
         for (int k = 0; k < 16; k++) begin
            step("sweep");
            if (e_active && e_digit == 0 && !seen) begin
               seen = 1'b1;
               chk("sweep_code", LED, seg_of(c));
               if (c == 0)  chk("sweep_code0", LED, 7'b0000001);
               if (c == 36) chk("sweep_code36", LED, 7'b1111110);
               if (c == 37) chk("sweep_code37", LED, 7'b1111111);
               if (c == 63) chk("sweep_code63", LED, 7'b1111111);
            end
         end
         chk("sweep_seen", 32'(seen), 1);
      end

      // Scroll wrap with eight distinct characters.
      for (int i = 0; i < ML; i++) write(i, 10 + 3 * i, "scroll_load");
      scroll_clr = 1'b1;
      step("scroll_clr");
      scroll_clr = 1'b0;
      scroll_en  = 1'b1;
      run(6 * SD, "scroll");
      seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         step("scroll6");
         if (e_active && e_digit == 2 && !seen) begin
            seen = 1'b1;
            chk("scroll6_dig2_buf0", LED, seg_of(int'(m_mem[0])));
         end
      end
      chk("scroll6_seen", 32'(seen), 1);
      run(8 * SD - m_en, "scroll");
      for (int k = 0; k < 16; k++) begin
         step("scroll8");
         if (e_active) chk("scroll8_unscrolled", LED, seg_of(int'(m_mem[e_digit])));
      end
      $display("scroll wrap done: steps=%0d", m_en / SD);

      // Pause: offset must hold for 100 cycles.
      run(2 * SD, "scroll");
      off_before = (m_en / SD) % ML;
      scroll_en  = 1'b0;
      run(100, "pause");
      seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         step("pause_chk");
         if (e_active && e_digit == 0 && !seen) begin
            seen = 1'b1;
            chk("pause_dig0", LED, seg_of(int'(m_mem[off_before])));
         end
      end
      chk("pause_seen", 32'(seen), 1);
      $display("pause done: offset=%0d", off_before);

      // Clear exactly at a scroll wrap, together with scroll_en.
      scroll_en = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 2 * SD && !seen; k++) begin
         if (m_en % SD == SD - 1) seen = 1'b1;
         else step("clr_wait");
      end
      chk("clr_wrap_found", 32'(seen), 1);
      scroll_clr = 1'b1;
      step("clr_at_wrap");
      scroll_clr = 1'b0;
      scroll_en  = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         step("clr_chk");
         if (e_active && e_digit == 0 && !seen) begin
            seen = 1'b1;
            chk("clr_dig0_buf0", LED, seg_of(int'(m_mem[0])));
         end
      end
      chk("clr_seen", 32'(seen), 1);
      $display("clear at wrap done");

      // Write the incoming character on the cycle the offset steps.
      scroll_en = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 2 * SD && !seen; k++) begin
         if (m_en % SD == SD - 1) seen = 1'b1;
         else step("simul_wait");
      end
      chk("simul_wrap_found", 32'(seen), 1);
      cur_off  = (m_en / SD) % ML;
      scroll_en = 1'b1;
      write((cur_off + 4) % ML, 36, "simul");
      scroll_en = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         step("simul_chk");
         if (e_active && e_digit == 3 && !seen) begin
            seen = 1'b1;
            chk("simul_dig3_dash", LED, 7'b1111110);
         end
      end
      chk("simul_seen", 32'(seen), 1);

      // Random traffic with one asynchronous reset in the middle.
      for (int i = 0; i < 1500; i++) begin
         scroll_en  = ($urandom_range(3) != 0);
         scroll_clr = ($urandom_range(63) == 0);
         if (i == 700) do_reset("rand");
         if ($urandom_range(5) == 0) begin
            write(int'($urandom_range(ML - 1)), int'($urandom_range(63)), "rand");
         end else begin
            step("rand");
         end
      end
      scroll_en  = 1'b0;
      scroll_clr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the bench always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
